// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline types, hazard-controller states and the bubble control word.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  typedef struct packed {
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
    logic brnch;
    logic mem_to_rgs;
  } ctrl_t;
  localparam ctrl_t BUBBLE_CTRL = '0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clock)
    if (reset) count <= '0;
    else if (inc && count != '1) count <= count + WIDTH'(1);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and memory-freeze sequencing for the 5-stage pipeline.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TMO = 8,
  parameter int CNT_W   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_ra,
  input  logic [REG_ADDR_W-1:0] id_rb,
  input  logic                  id_uses_rb,
  input  logic [REG_ADDR_W-1:0] idex_wa,
  input  logic                  idex_mem_rd,
  input  logic                  idex_reg_wr,
  input  logic                  ex_brnch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  pc_wr,
  output logic                  ifid_wr,
  output logic                  ifid_flush,
  output logic                  idex_wr,
  output logic                  idex_bubble,
  output logic                  exmem_wr,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      wait_cnt
);
  localparam int TW = $clog2(MEM_TMO + 1);
  state_t        state;
  logic [TW-1:0] timer;
  logic          active, freeze, tmo, hold, run, lu_haz, brn, stl;
  assign active = state != ERR;
  assign freeze = mem_req & ~mem_ack;
  // Once the timer has expired a late ack is ignored: the cycle stays frozen.
  assign tmo    = state == MEM_WAIT && timer == TW'(MEM_TMO);
  assign hold   = active & (freeze | tmo);
  assign run    = active & ~hold;
  assign lu_haz = id_valid & idex_mem_rd & idex_reg_wr & (idex_wa != '0) &
                  ((idex_wa == id_ra) | (id_uses_rb & (idex_wa == id_rb)));
  assign brn    = run & ex_brnch_taken;
  assign stl    = run & ~ex_brnch_taken & lu_haz;
  always_comb begin
    pc_wr       = ~reset & run & ~stl;
    ifid_wr     = ~reset & run & ~brn & ~stl;
    idex_wr     = ~reset & run;
    exmem_wr    = ~reset & run;
    ifid_flush  = reset | brn;
    idex_bubble = reset | brn | stl;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state   <= RUN;
      timer   <= '0;
      mem_err <= 1'b0;
    end else if (state == RUN) begin
      state <= freeze ? MEM_WAIT : RUN;
      timer <= freeze ? TW'(1) : '0;
    end else if (state == MEM_WAIT) begin
      state   <= tmo ? ERR : freeze ? MEM_WAIT : RUN;
      timer   <= tmo ? timer : freeze ? timer + TW'(1) : '0;
      mem_err <= tmo;
    end
  sat_counter #(.WIDTH(CNT_W)) u_stall (.clock(clock), .reset(reset), .inc(stl),  .count(stall_cnt));
  sat_counter #(.WIDTH(CNT_W)) u_flush (.clock(clock), .reset(reset), .inc(brn),  .count(flush_cnt));
  sat_counter #(.WIDTH(CNT_W)) u_wait  (.clock(clock), .reset(reset), .inc(hold), .count(wait_cnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed tests of stall, flush, freeze, timeout and counter saturation.
module tb_hazard_ctrl;
  localparam int MEM_TMO = 8;
  localparam int CNT_W   = 4;
  localparam logic [5:0] NORM = 6'b110101;
  localparam logic [5:0] FRZ  = 6'b000000;
  localparam logic [5:0] BR   = 6'b101111;
  localparam logic [5:0] STL  = 6'b000111;
  localparam logic [5:0] RST  = 6'b001010;
  logic clock = 0, reset = 1;
  logic id_valid, id_uses_rb, idex_mem_rd, idex_reg_wr, ex_brnch_taken, mem_req, mem_ack;
  logic [4:0] id_ra, id_rb, idex_wa;
  logic pc_wr, ifid_wr, ifid_flush, idex_wr, idex_bubble, exmem_wr, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
  logic [5:0] ctl;
  int errors = 0, checks = 0;
  assign ctl = {pc_wr, ifid_wr, ifid_flush, idex_wr, idex_bubble, exmem_wr};
  always #5 clock = ~clock;
  hazard_ctrl #(.MEM_TMO(MEM_TMO), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_uses_rb(id_uses_rb), .idex_wa(idex_wa), .idex_mem_rd(idex_mem_rd),
    .idex_reg_wr(idex_reg_wr), .ex_brnch_taken(ex_brnch_taken), .mem_req(mem_req),
    .mem_ack(mem_ack), .pc_wr(pc_wr), .ifid_wr(ifid_wr), .ifid_flush(ifid_flush),
    .idex_wr(idex_wr), .idex_bubble(idex_bubble), .exmem_wr(exmem_wr), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt));

  task automatic idle();
    id_valid = 1; id_ra = 1; id_rb = 2; id_uses_rb = 1; idex_wa = 3;
    idex_mem_rd = 0; idex_reg_wr = 1; ex_brnch_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic load_use(input logic [4:0] wa, input logic [4:0] ra);
    idle(); idex_mem_rd = 1; idex_wa = wa; id_ra = ra;
  endtask

  task automatic test_reset();
    idle(); reset = 1; #1;
    checks++; if (ctl !== RST) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, RST); end
    step(); step();
    checks++; if ({mem_err, stall_cnt, flush_cnt, wait_cnt} !== '0) begin errors++;
      $display("FAIL reset_state: got err=%b s=%0d f=%0d w=%0d want all 0", mem_err, stall_cnt, flush_cnt, wait_cnt); end
    reset = 0; #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL reset_release: got %b want %b", ctl, NORM); end
  endtask

  task automatic test_load_use();
    load_use(5, 5); #1;
    checks++; if (ctl !== STL) begin errors++; $display("FAIL lu_stall: got %b want %b", ctl, STL); end
    step(); idle(); #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL lu_after: got %b want %b", ctl, NORM); end
    checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    load_use(0, 0); #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL lu_x0: got %b want %b", ctl, NORM); end
    load_use(5, 5); id_valid = 0; #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL lu_invalid: got %b want %b", ctl, NORM); end
    step();
    checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL lu_x0_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_rb_gating();
    load_use(7, 3); id_rb = 7; id_uses_rb = 0; #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL rb_unused: got %b want %b", ctl, NORM); end
    id_uses_rb = 1; #1;
    checks++; if (ctl !== STL) begin errors++; $display("FAIL rb_used: got %b want %b", ctl, STL); end
    step();
    checks++; if (stall_cnt !== 2) begin errors++; $display("FAIL rb_cnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_branch();
    load_use(5, 5); ex_brnch_taken = 1; #1;
    checks++; if (ctl !== BR) begin errors++; $display("FAIL br_ctl: got %b want %b", ctl, BR); end
    step(); idle(); #1;
    checks++; if ({flush_cnt, stall_cnt} !== {4'd1, 4'd2}) begin errors++;
      $display("FAIL br_cnt: got f=%0d s=%0d want f=1 s=2", flush_cnt, stall_cnt); end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      idle(); mem_req = 1; ex_brnch_taken = 1; #1;
      checks++; if (ctl !== FRZ) begin errors++; $display("FAIL wait_frz%0d: got %b want %b", i, ctl, FRZ); end
      step();
    end
    mem_ack = 1; #1;
    checks++; if (ctl !== BR) begin errors++; $display("FAIL wait_ack_branch: got %b want %b", ctl, BR); end
    step(); idle(); #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL wait_after: got %b want %b", ctl, NORM); end
    checks++; if ({wait_cnt, flush_cnt} !== {4'd3, 4'd2}) begin errors++;
      $display("FAIL wait_cnt: got w=%0d f=%0d want w=3 f=2", wait_cnt, flush_cnt); end
  endtask

  task automatic test_timeout_edge();
    idle(); mem_req = 1;
    repeat (MEM_TMO - 1) step();
    mem_ack = 1; #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL tmo_edge_ack: got %b want %b", ctl, NORM); end
    step(); idle(); #1;
    checks++; if ({mem_err, ctl} !== {1'b0, NORM}) begin errors++;
      $display("FAIL tmo_edge_run: got err=%b ctl=%b want err=0 ctl=%b", mem_err, ctl, NORM); end
    checks++; if (wait_cnt !== 10) begin errors++; $display("FAIL tmo_edge_cnt: got %0d want 10", wait_cnt); end
  endtask

  task automatic test_timeout();
    idle(); mem_req = 1;
    repeat (MEM_TMO) step();
    checks++; if (mem_err !== 0) begin errors++; $display("FAIL tmo_early_err: got %b want 0", mem_err); end
    mem_ack = 1; #1;
    checks++; if (ctl !== FRZ) begin errors++; $display("FAIL tmo_late_ack: got %b want %b", ctl, FRZ); end
    step(); idle(); ex_brnch_taken = 1; #1;
    checks++; if ({mem_err, ctl} !== {1'b1, FRZ}) begin errors++;
      $display("FAIL tmo_err: got err=%b ctl=%b want err=1 ctl=%b", mem_err, ctl, FRZ); end
    step(); step();
    checks++; if ({mem_err, wait_cnt, flush_cnt} !== {1'b1, 4'd15, 4'd2}) begin errors++;
      $display("FAIL tmo_hold: got err=%b w=%0d f=%0d want err=1 w=15 f=2", mem_err, wait_cnt, flush_cnt); end
    reset = 1; #1;
    checks++; if (ctl !== RST) begin errors++; $display("FAIL tmo_reset_ctl: got %b want %b", ctl, RST); end
    step(); reset = 0; idle(); #1;
    checks++; if ({mem_err, ctl, wait_cnt} !== {1'b0, NORM, 4'd0}) begin errors++;
      $display("FAIL tmo_reset_run: got err=%b ctl=%b w=%0d want err=0 ctl=%b w=0", mem_err, ctl, wait_cnt, NORM); end
    mem_req = 1; step(); step(); mem_ack = 1; #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL tmo_no_residual: got %b want %b", ctl, NORM); end
    step();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      load_use(9, 9); step();
    end
    idle(); #1;
    checks++; if (stall_cnt !== 15) begin errors++; $display("FAIL sat_cnt: got %0d want 15", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rb_gating();
    test_branch();
    test_mem_wait();
    test_timeout_edge();
    test_timeout();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
